wave_sequencer: RTL and testbench

Programmable sequencer that time-shares one R2R ladder and one PWM output pin among three waveform generators: triangle, sawtooth and square. It plays a small step table of (waveform, duration) entries. For each step it enables exactly one generator and routes that generator's R2R/PWM outputs to the board. Between steps it inserts a break-before-make gap with all generators disabled, so the next generator restarts from its reset phase. It sits above the generator instances and drives their `enable` inputs.

---
 rtl/wave_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// wave_sequencer: plays a small (waveform, duration) step table over three
// generators that share one R2R ladder and one PWM pin. Exactly one generator
// is enabled per step, with a break-before-make gap (all generators off)
// between steps so each generator restarts from its reset phase.
//
// Build option: define WAVE_SEQ_LOOP_EN to restart the table at entry 0 at the
// end of the sequence (runs until abort, done never pulses). Undefined: the
// sequence finishes with a done pulse and a return to IDLE.
//
// state | meaning
// IDLE  | waiting for start; table writable
// LOAD  | latch mode/dur/last of table[idx]
// GAP   | all generators off for GAP_CYCLES cycles
// RUN   | selected generator enabled and routed for dur ticks
// NEXT  | advance to the next entry or end the sequence

module wave_sequencer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int DUR_WIDTH  = 16,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [1:0]                 cfg_mode,
  input  logic [DUR_WIDTH-1:0]       cfg_dur,
  input  logic                       cfg_last,
  input  logic [WIDTH-1:0]           tri_r2r,
  input  logic [WIDTH-1:0]           saw_r2r,
  input  logic [WIDTH-1:0]           sq_r2r,
  input  logic                       tri_pwm,
  input  logic                       saw_pwm,
  input  logic                       sq_pwm,
  output logic [2:0]                 gen_en,
  output logic [WIDTH-1:0]           r2r_out,
  output logic                       pwm_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       cfg_err
);

  localparam int IW       = $clog2(DEPTH);
  localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_RUN,
    S_NEXT
  } state_t;

  // Step table
  logic [1:0]           tbl_mode_q [DEPTH];
  logic [DUR_WIDTH-1:0] tbl_dur_q  [DEPTH];
  logic                 tbl_last_q [DEPTH];
  logic                 cfg_err_q;

  // Sequencer state
  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [1:0]           mode_q;
  logic [DUR_WIDTH-1:0] dur_q;
  logic                 last_q;
  logic [GW-1:0]        gap_q;
  logic [PW-1:0]        presc_q;
  logic [DUR_WIDTH-1:0] remain_q;
  logic [2:0]           gen_en_q;
  logic [WIDTH-1:0]     r2r_q;
  logic                 pwm_q;
  logic                 busy_q;
  logic                 done_q;

  logic [2:0]           en_sel;
  logic [WIDTH-1:0]     src_r2r;
  logic                 src_pwm;
  logic                 run_end;

  // Table writes are only taken in IDLE; a write while busy is flagged instead
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_mode_q[i] <= 2'd0;
        tbl_dur_q[i]  <= '0;
        tbl_last_q[i] <= 1'b1;
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (state_q != S_IDLE);
      if (cfg_we && (state_q == S_IDLE)) begin
        tbl_mode_q[cfg_addr] <= cfg_mode;
        tbl_dur_q[cfg_addr]  <= cfg_dur;
        tbl_last_q[cfg_addr] <= cfg_last;
      end
    end
  end

  // Enable pattern and routed source for the latched mode (mode 0 is silence)
  always_comb begin
    en_sel  = 3'b000;
    src_r2r = '0;
    src_pwm = 1'b0;
    case (mode_q)
      2'd1: begin en_sel = 3'b001; src_r2r = tri_r2r; src_pwm = tri_pwm; end
      2'd2: begin en_sel = 3'b010; src_r2r = saw_r2r; src_pwm = saw_pwm; end
      2'd3: begin en_sel = 3'b100; src_r2r = sq_r2r;  src_pwm = sq_pwm;  end
      default: ;
    endcase
  end

  // Last RUN cycle: final prescaler slot of the final tick
  assign run_end = (state_q == S_RUN) && (presc_q == '0) &&
                   (remain_q == DUR_WIDTH'(1));

  // Sequencer FSM with registered enables, routing and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mode_q   <= 2'd0;
      dur_q    <= '0;
      last_q   <= 1'b0;
      gap_q    <= '0;
      presc_q  <= '0;
      remain_q <= '0;
      gen_en_q <= 3'b000;
      r2r_q    <= '0;
      pwm_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      r2r_q  <= '0;
      pwm_q  <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q  <= S_IDLE;
        idx_q    <= '0;
        gen_en_q <= 3'b000;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_LOAD;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            mode_q <= tbl_mode_q[idx_q];
            dur_q  <= tbl_dur_q[idx_q];
            last_q <= tbl_last_q[idx_q];
            gap_q  <= GW'(GAP_CYCLES - 1);
            // A zero-length step is skipped entirely, gap included
            state_q <= (tbl_dur_q[idx_q] == '0) ? S_NEXT : S_GAP;
          end
          S_GAP: begin
            if (gap_q == '0) begin
              state_q  <= S_RUN;
              gen_en_q <= en_sel;
              presc_q  <= PW'(TICK_DIV - 1);
              remain_q <= dur_q;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          S_RUN: begin
            if (presc_q == '0) begin
              presc_q <= PW'(TICK_DIV - 1);
              if (!run_end) begin
                remain_q <= remain_q - 1'b1;
              end
            end else begin
              presc_q <= presc_q - 1'b1;
            end
            if (run_end) begin
              state_q  <= S_NEXT;
              gen_en_q <= 3'b000;
            end else begin
              // Routed output is only live when both this and the next cycle are RUN
              r2r_q <= src_r2r;
              pwm_q <= src_pwm;
            end
          end
          S_NEXT: begin
            if (!last_q && (idx_q != IW'(DEPTH - 1))) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_LOAD;
            end else begin
`ifdef WAVE_SEQ_LOOP_EN
              idx_q   <= '0;
              state_q <= S_LOAD;
`else
              idx_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign gen_en   = gen_en_q;
  assign r2r_out  = r2r_q;
  assign pwm_out  = pwm_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Testbench for wave_sequencer: a per-cycle expected timeline is built from
// the step table (LOAD, GAP, RUN, NEXT lengths) and compared each cycle,
// with random generator samples, random spurious starts and rejected writes.
module tb_wave_sequencer;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 8;
  localparam int DUR_WIDTH  = 4;
  localparam int CLOCK_FREQ = 1000;
  localparam int TICK_HZ    = 100;
  localparam int TICK_DIV   = CLOCK_FREQ / TICK_HZ;
  localparam int GAP_CYCLES = 4;
  localparam int IW         = $clog2(DEPTH);
`ifdef WAVE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [IW-1:0]        cfg_addr = '0;
  logic [1:0]           cfg_mode = '0;
  logic [DUR_WIDTH-1:0] cfg_dur = '0;
  logic                 cfg_last = 1'b0;
  logic [WIDTH-1:0]     tri_r2r = '0, saw_r2r = '0, sq_r2r = '0;
  logic                 tri_pwm = 1'b0, saw_pwm = 1'b0, sq_pwm = 1'b0;
  logic [2:0]           gen_en;
  logic [WIDTH-1:0]     r2r_out;
  logic                 pwm_out;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        step_idx;
  logic                 cfg_err;

  wave_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DUR_WIDTH(DUR_WIDTH),
    .CLOCK_FREQ(CLOCK_FREQ), .TICK_HZ(TICK_HZ), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_dur(cfg_dur), .cfg_last(cfg_last),
    .tri_r2r(tri_r2r), .saw_r2r(saw_r2r), .sq_r2r(sq_r2r),
    .tri_pwm(tri_pwm), .saw_pwm(saw_pwm), .sq_pwm(sq_pwm),
    .gen_en(gen_en), .r2r_out(r2r_out), .pwm_out(pwm_out),
    .busy(busy), .done(done), .step_idx(step_idx), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit run;
    int mode;
    bit busy;
    bit done;
    int idx;
  } exp_t;

  exp_t trace[$];
  int   m_mode [DEPTH];
  int   m_dur  [DEPTH];
  bit   m_last [DEPTH];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input int mode);
    case (mode)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void push_exp(input bit run, input int mode, input bit bsy,
                                   input bit dn, input int idx);
    exp_t e;
    e.run = run; e.mode = mode; e.busy = bsy; e.done = dn; e.idx = idx;
    trace.push_back(e);
  endfunction

  // Expected per-cycle timeline from the table, starting the cycle after start is sampled
  function automatic void build_trace();
    trace.delete();
    for (int r = 0; r < (LOOP ? 3 : 1); r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        push_exp(1'b0, 0, 1'b1, 1'b0, i);
        if (m_dur[i] != 0) begin
          for (int g = 0; g < GAP_CYCLES; g++) push_exp(1'b0, 0, 1'b1, 1'b0, i);
          for (int c = 0; c < m_dur[i] * TICK_DIV; c++) push_exp(1'b1, m_mode[i], 1'b1, 1'b0, i);
        end
        push_exp(1'b0, 0, 1'b1, 1'b0, i);
        if (m_last[i]) break;
      end
    end
    if (!LOOP) push_exp(1'b0, 0, 1'b0, 1'b1, 0);
  endfunction

  task automatic drive_src();
    tri_r2r = WIDTH'($urandom); saw_r2r = WIDTH'($urandom); sq_r2r = WIDTH'($urandom);
    tri_pwm = 1'($urandom);     saw_pwm = 1'($urandom);     sq_pwm = 1'($urandom);
  endtask

  task automatic write_entry(input int addr, input int mode, input int dur, input bit last);
    cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_mode = 2'(mode);
    cfg_dur = DUR_WIDTH'(dur); cfg_last = last;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle_write", cfg_err, 0);
    m_mode[addr] = mode; m_dur[addr] = dur; m_last[addr] = last;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_r2r"}, r2r_out, 0);
    check({tag, "_pwm"}, pwm_out, 0);
    check({tag, "_step_idx"}, step_idx, 0);
  endtask

  // Start a sequence and follow it cycle by cycle; optional abort and a write while busy
  task automatic play(input int abort_at, input int bad_we_at);
    exp_t e;
    bit prev_run = 1'b0, we_prev = 1'b0, busy_prev = 1'b0, aborted = 1'b0;
    logic [WIDTH-1:0] p_tri, p_saw, p_sq, exp_r2r;
    logic p_tp, p_sp, p_qp, exp_pwm;
    build_trace();
    if (LOOP && (abort_at < 0 || abort_at >= trace.size())) abort_at = trace.size() - 1;
    start = 1'b1;
    drive_src();
    p_tri = tri_r2r; p_saw = saw_r2r; p_sq = sq_r2r; p_tp = tri_pwm; p_sp = saw_pwm; p_qp = sq_pwm;
    for (int j = 0; j < trace.size(); j++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      e = trace[j];
      exp_r2r = '0; exp_pwm = 1'b0;
      if (e.run && prev_run) begin
        case (e.mode)
          1: begin exp_r2r = p_tri; exp_pwm = p_tp; end
          2: begin exp_r2r = p_saw; exp_pwm = p_sp; end
          3: begin exp_r2r = p_sq;  exp_pwm = p_qp; end
          default: ;
        endcase
      end
      check("gen_en", gen_en, e.run ? onehot(e.mode) : 3'b000);
      check("busy", busy, e.busy);
      check("done", done, e.done);
      check("step_idx", step_idx, e.idx);
      check("r2r_out", r2r_out, exp_r2r);
      check("pwm_out", pwm_out, exp_pwm);
      check("cfg_err", cfg_err, we_prev && busy_prev);
      drive_src();
      p_tri = tri_r2r; p_saw = saw_r2r; p_sq = sq_r2r; p_tp = tri_pwm; p_sp = saw_pwm; p_qp = sq_pwm;
      prev_run = e.run; busy_prev = e.busy; we_prev = 1'b0;
      if (e.busy && $urandom_range(0, 7) == 0) start = 1'b1;
      if (j == abort_at) begin
        abort = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (j == bad_we_at && e.busy) begin
        cfg_we = 1'b1; cfg_addr = IW'($urandom); cfg_mode = 2'($urandom);
        cfg_dur = DUR_WIDTH'($urandom); cfg_last = 1'($urandom);
        we_prev = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    check_idle(aborted ? "after_abort" : "after_done");
    check("after_cfg_err", cfg_err, 0);
    @(negedge clk);
    check("settled_busy", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mode[i] = 0; m_dur[i] = 0; m_last[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_cfg_err", cfg_err, 0);

    // Cleared table: LOAD, NEXT, done
    play(-1, -1);

    // Triangle 2 ticks, square 1 tick
    write_entry(0, 1, 2, 1'b0);
    write_entry(1, 3, 1, 1'b1);
    play(-1, -1);

    // Abort in the middle of step 0's RUN
    play(1 + GAP_CYCLES + 7, -1);

    // Write while busy is rejected; replay shows the table unchanged
    play(-1, 8);
    play(-1, -1);

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_gen_en", gen_en, 0);
    @(negedge clk);
    check("start_abort_busy2", busy, 0);

    // Zero-duration sawtooth is skipped
    write_entry(0, 2, 0, 1'b0);
    write_entry(1, 1, 1, 1'b1);
    play(-1, -1);

    // Full-scale duration must not wrap
    write_entry(0, 3, (1 << DUR_WIDTH) - 1, 1'b1);
    play(-1, -1);

    // Silence step is still timed, and the table runs off its end at DEPTH-1
    for (int i = 0; i < DEPTH; i++) write_entry(i, i % 4, (i % 3 == 0) ? 1 : 0, 1'b0);
    play(-1, -1);

    // Random tables
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      play(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 80)) : -1,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 40)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
